// File: rtl/synth_audio_pkg.sv
// Audio-path constants and the signed sample type shared by the NCO and the I2S output stage.
package synth_audio_pkg;
   localparam int unsigned SAMPLE_WIDTH = 16;
   localparam int unsigned SLOT_WIDTH   = 32;
   localparam int unsigned BCLK_DIV     = 4;

   typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
endpackage

// File: rtl/i2s_clock_gen.sv
// I2S timing: bclk divider, frame bit counter, lrclk, and the bclk-fall / frame-start strobes.
module i2s_clock_gen #(
   parameter int unsigned BCLK_DIV   = synth_audio_pkg::BCLK_DIV,
   parameter int unsigned SLOT_WIDTH = synth_audio_pkg::SLOT_WIDTH,
   localparam int unsigned DIV_W     = $clog2(BCLK_DIV),
   localparam int unsigned BIT_W     = $clog2(2*SLOT_WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   output logic             bclk,
   output logic             lrclk,
   output logic             fall_evt,
   output logic             frame_start,
   output logic [BIT_W-1:0] bit_next
);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV-1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV/2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2*SLOT_WIDTH-1);
   localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_WIDTH);

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_next;
   logic [BIT_W-1:0] bit_cnt;

   // bit_next is only meaningful on fall_evt cycles; consumers gate on it.
   always_comb begin
      fall_evt    = (div_cnt == DIV_LAST);
      div_next    = fall_evt ? '0 : div_cnt + DIV_W'(1);
      bit_next    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
      frame_start = fall_evt && (bit_cnt == BIT_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         bit_cnt <= BIT_LAST;
         bclk    <= 1'b0;
         lrclk   <= 1'b0;
      end else begin
         div_cnt <= div_next;
         bclk    <= (div_next >= DIV_HALF);
         if (fall_evt) begin
            bit_cnt <= bit_next;
            lrclk   <= (bit_next >= SLOT);
         end
      end
   end
endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S mono transmitter: latches one sample per frame, sends it MSB-first on both slots.
module i2s_transmitter #(
   parameter int unsigned BCLK_DIV     = synth_audio_pkg::BCLK_DIV,
   parameter int unsigned SAMPLE_WIDTH = synth_audio_pkg::SAMPLE_WIDTH,
   parameter int unsigned SLOT_WIDTH   = synth_audio_pkg::SLOT_WIDTH
) (
   input  logic                    master_clk,
   input  logic                    rst,
   input  logic [SAMPLE_WIDTH-1:0] sample_in,
   output logic                    sample_clk_en,
   output logic                    i2s_bclk,
   output logic                    i2s_lrclk,
   output logic                    i2s_sdata
);
   localparam int unsigned BIT_W = $clog2(2*SLOT_WIDTH);
   localparam logic [BIT_W-1:0] SLOT = BIT_W'(SLOT_WIDTH);

   if ((BCLK_DIV % 2 != 0) || (BCLK_DIV < 2)) begin : g_bad_div
      $error("i2s_transmitter: BCLK_DIV must be even and >= 2");
   end
   if (SLOT_WIDTH <= SAMPLE_WIDTH) begin : g_bad_slot
      $error("i2s_transmitter: SLOT_WIDTH must exceed SAMPLE_WIDTH");
   end

   logic                    fall_evt;
   logic                    frame_start;
   logic [BIT_W-1:0]        bit_next;
   logic [BIT_W-1:0]        pos;
   logic [SAMPLE_WIDTH-1:0] held;
   logic                    sdata_next;

   i2s_clock_gen #(
      .BCLK_DIV   (BCLK_DIV),
      .SLOT_WIDTH (SLOT_WIDTH)
   ) u_clock_gen (
      .clk         (master_clk),
      .rst         (rst),
      .bclk        (i2s_bclk),
      .lrclk       (i2s_lrclk),
      .fall_evt    (fall_evt),
      .frame_start (frame_start),
      .bit_next    (bit_next)
   );

   // Slot position 0 is the I2S one-bclk delay; sample bits occupy positions 1..SAMPLE_WIDTH.
   always_comb begin
      pos        = (bit_next >= SLOT) ? bit_next - SLOT : bit_next;
      sdata_next = 1'b0;
      for (int unsigned i = 1; i <= SAMPLE_WIDTH; i++) begin
         if (pos == BIT_W'(i)) sdata_next = held[SAMPLE_WIDTH-i];
      end
   end

   always_ff @(posedge master_clk or posedge rst) begin
      if (rst) begin
         held          <= '0;
         i2s_sdata     <= 1'b0;
         sample_clk_en <= 1'b0;
      end else begin
         sample_clk_en <= frame_start;
         if (frame_start) held <= sample_in;
         if (fall_evt) i2s_sdata <= sdata_next;
      end
   end
endmodule
